i2c_codec_rx: RTL and testbench

I2C write-only target that receives the 3-byte register-write transaction the codec-programming master issues: device byte, then register high byte, then register low byte. It decodes START and STOP conditions on an oversampled bus and ACKs each byte that matches. On each completed transfer it presents the 16-bit word `[REG, DATA]` with a one-cycle strobe. It sits on the shared SCLK/SDAT lines as an on-FPGA codec stand-in and doubles as the bus monitor for master verification.

---
 rtl/i2c_codec_rx.sv | 131 +++++++++++++
 tb/tb_i2c_codec_rx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/i2c_codec_rx.sv
// Write-only I2C target for the codec register-write transaction (device, reg, data).
// Decodes START/STOP on an oversampled bus, ACKs matching bytes and emits {REG, DATA}.
module i2c_codec_rx #(
    parameter logic [7:0] DEV_BYTE = 8'h35
) (
    input  logic        CLK,
    input  logic        RST_L,
    input  logic        I2C_SCLK,
    inout  wire         I2C_SDAT,
    output logic [15:0] RX_DATA,
    output logic        RX_VALID,
    output logic        BUSY,
    output logic        ERR
);
    typedef enum logic [2:0] {IDLE, DEV, ACK, BYTE, DONE, WAIT_STOP} state_t;

    state_t      state;
    logic [2:0]  bit_cnt;
    logic [1:0]  byte_idx;
    logic [7:0]  shift;
    logic [7:0]  hi;
    logic        sda_drive;
    logic [1:0]  pin;

    assign pin      = {I2C_SDAT, I2C_SCLK};
    assign I2C_SDAT = sda_drive ? 1'b0 : 1'bz;

    // Two synchronizer stages plus one history stage per line; idle bus is high.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic [2:0] q;
            always_ff @(posedge CLK or negedge RST_L) begin
                if (!RST_L) q <= 3'b111;
                else        q <= {q[1:0], pin[gi]};
            end
        end
    endgenerate

    logic scl_s, scl_d, sda_s, sda_d;
    logic scl_rise, scl_fall, start_det, stop_det, mid_byte;

    assign scl_s     = g_sync[0].q[1];
    assign scl_d     = g_sync[0].q[2];
    assign sda_s     = g_sync[1].q[1];
    assign sda_d     = g_sync[1].q[2];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
    // The SCL rise that precedes a START/STOP is the condition's own clock, not a data bit.
    assign mid_byte  = bit_cnt > 3'd1;

    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            byte_idx  <= 2'd0;
            shift     <= 8'h00;
            hi        <= 8'h00;
            sda_drive <= 1'b0;
            RX_DATA   <= 16'h0000;
            RX_VALID  <= 1'b0;
            BUSY      <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            RX_VALID <= 1'b0;
            if (start_det) begin
                state     <= DEV;
                bit_cnt   <= 3'd0;
                byte_idx  <= 2'd0;
                sda_drive <= 1'b0;
                BUSY      <= 1'b1;
                ERR       <= mid_byte;
            end else if (stop_det) begin
                state     <= IDLE;
                bit_cnt   <= 3'd0;
                byte_idx  <= 2'd0;
                sda_drive <= 1'b0;
                BUSY      <= 1'b0;
                if (mid_byte) ERR <= 1'b1;
            end else begin
                case (state)
                    DEV, BYTE, DONE: begin
                        if (scl_rise) begin
                            shift   <= {shift[6:0], sda_s};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                // DONE only sees surplus bytes, which are never ACKed.
                                if ((state == DONE) ||
                                    ((state == DEV) && ({shift[6:0], sda_s} != DEV_BYTE))) begin
                                    ERR   <= 1'b1;
                                    state <= WAIT_STOP;
                                end else begin
                                    state <= ACK;
                                end
                            end
                        end
                    end
                    ACK: begin
                        if (scl_fall) begin
                            if (!sda_drive) begin
                                sda_drive <= 1'b1;
                            end else begin
                                sda_drive <= 1'b0;
                                case (byte_idx)
                                    2'd0: begin
                                        byte_idx <= 2'd1;
                                        state    <= BYTE;
                                    end
                                    2'd1: begin
                                        hi       <= shift;
                                        byte_idx <= 2'd2;
                                        state    <= BYTE;
                                    end
                                    default: begin
                                        RX_DATA  <= {hi, shift};
                                        RX_VALID <= 1'b1;
                                        byte_idx <= 2'd3;
                                        state    <= DONE;
                                    end
                                endcase
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_codec_rx.sv
// Bench for i2c_codec_rx: bit-banged I2C master, transaction-level reference model,
// and a per-cycle monitor checking every RX_VALID against the expected word queue.
module tb_i2c_codec_rx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl = 1'b1;
    logic        sda_o = 1'b1;
    wire         sdat;
    logic [15:0] rx_data;
    logic        rx_valid, busy, err;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          fall_cyc = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_word = 16'h0000;
    logic        prev_valid = 1'b0;

    pullup (sdat);
    assign sdat = sda_o ? 1'bz : 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    i2c_codec_rx #(.DEV_BYTE(8'h35)) dut (
        .CLK(clk), .RST_L(rst_n), .I2C_SCLK(scl), .I2C_SDAT(sdat),
        .RX_DATA(rx_data), .RX_VALID(rx_valid), .BUSY(busy), .ERR(err)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every strobe must be expected, one cycle wide, 3-4 CLK after the last SCL fall.
    always @(negedge clk) begin : monitor
        int d;
        if (rx_valid) begin
            d = cyc - fall_cyc;
            chk("valid_width", prev_valid, 0);
            checks++;
            if (d < 3 || d > 4) begin
                errors++;
                $display("FAIL valid_latency: got %0d cycles expected 3..4", d);
            end
            chk("valid_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("rx_data", rx_data, exp_q.pop_front());
            $display("rx word %04h at cycle %0d", rx_data, cyc);
        end
        prev_valid <= rx_valid;
    end

    task automatic wait_clk(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic scl_set(logic v);
        scl = v;
        if (!v) fall_cyc = cyc;
    endtask

    task automatic do_start();
        sda_o = 1'b1; wait_clk(5);
        scl_set(1'b1); wait_clk(5);
        sda_o = 1'b0; wait_clk(5);
        scl_set(1'b0);
    endtask

    task automatic do_stop();
        wait_clk(5); sda_o = 1'b0;
        wait_clk(5); scl_set(1'b1);
        wait_clk(5); sda_o = 1'b1;
        wait_clk(10);
        chk("sda_idle", sdat, 1);
    endtask

    // exp_line < 0 means the line value carries no information for this bit.
    task automatic do_bit(logic b, int exp_line, string name);
        wait_clk(5); sda_o = b;
        wait_clk(5); scl_set(1'b1);
        wait_clk(5);
        if (exp_line >= 0) chk(name, sdat, exp_line[0]);
        wait_clk(5); scl_set(1'b0);
    endtask

    task automatic do_byte(logic [7:0] b, bit ack);
        for (int i = 7; i >= 0; i--) do_bit(b[i], b[i] ? 1 : -1, "sda_released");
        do_bit(1'b1, ack ? 0 : 1, "ack");
    endtask

    // Reference: outcome follows from the byte list alone.
    task automatic run_txn(logic [7:0] b[$]);
        bit dev_ok;
        bit exp_err;
        dev_ok  = (b[0] == 8'h35);
        exp_err = !dev_ok || (b.size() > 3);
        if (dev_ok && b.size() >= 3) begin
            last_word = {b[1], b[2]};
            exp_q.push_back(last_word);
        end
        $display("txn dev=%02h len=%0d expect word=%04h err=%0d", b[0], b.size(), last_word, exp_err);
        do_start();
        chk("busy_after_start", busy, 1);
        for (int i = 0; i < b.size(); i++) do_byte(b[i], dev_ok && (i < 3));
        wait_clk(5);
        chk("valid_before_stop", exp_q.size(), 0);
        do_stop();
        chk("busy_after_stop", busy, 0);
        chk("err", err, exp_err);
        chk("rx_hold", rx_data, last_word);
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [7:0] q[$];
        wait_clk(3);
        chk("rst_rx_data", rx_data, 16'h0000);
        chk("rst_valid", rx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_sda", sdat, 1);
        rst_n = 1'b1;
        wait_clk(5);

        q = '{8'h35, 8'h0C, 8'h1F}; run_txn(q);
        chk("lit_0c1f", rx_data, 16'h0C1F);
        q = '{8'h35, 8'h12, 8'h34}; run_txn(q);
        chk("lit_1234", rx_data, 16'h1234);
        q = '{8'h35, 8'hAB, 8'hCD}; run_txn(q);
        chk("lit_abcd", rx_data, 16'hABCD);
        q = '{8'h34, 8'h56, 8'h78}; run_txn(q);
        chk("lit_bad_dev_hold", rx_data, 16'hABCD);
        chk("lit_bad_dev_err", err, 1);
        q = '{8'h35, 8'h5A, 8'hC3}; run_txn(q);
        chk("lit_err_cleared", err, 0);

        // STOP after 4 bits of the register byte
        $display("txn stop mid byte 2");
        do_start();
        do_byte(8'h35, 1'b1);
        for (int i = 7; i >= 4; i--) do_bit(i[0], -1, "none");
        do_stop();
        chk("partial_err", err, 1);
        chk("partial_busy", busy, 0);
        chk("partial_hold", rx_data, 16'h5AC3);

        // Reset while the second ACK is being driven
        $display("txn reset during ack 2");
        do_start();
        do_byte(8'h35, 1'b1);
        for (int i = 7; i >= 0; i--) do_bit(1'b0, -1, "none");
        wait_clk(5); sda_o = 1'b1;
        wait_clk(5); scl_set(1'b1);
        wait_clk(2);
        chk("ack2_driven", sdat, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_sda", sdat, 1);
        chk("rst_mid_rx_data", rx_data, 16'h0000);
        chk("rst_mid_valid", rx_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_err", err, 0);
        last_word = 16'h0000;
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(3);
        scl_set(1'b0);
        do_stop();
        q = '{8'h35, 8'h0A, 8'h55}; run_txn(q);
        chk("lit_0a55", rx_data, 16'h0A55);

        q = '{8'h35, 8'h01, 8'h02, 8'h03}; run_txn(q);
        chk("lit_0102", rx_data, 16'h0102);
        chk("lit_extra_err", err, 1);

        for (int t = 0; t < 30; t++) begin
            int n;
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 3;
            q.delete();
            q.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h35);
            for (int i = 1; i < n; i++) q.push_back(8'($urandom));
            run_txn(q);
        end

        wait_clk(10);
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
